fifo_uart_drain: RTL and testbench

Read-side consumer for the `cdc_fifo` read port. It pops two `DATA_WIDTH`-bit words from the FIFO, low word first, and packs them into one `2*DATA_WIDTH`-bit byte. It then transmits that byte LSB-first as an 8N1 UART frame on a single pin. It runs entirely in the FIFO read clock domain and turns the FIFO into a serial debug/streaming output for the chip top.

---
 rtl/fifo_uart_drain_pkg.sv | 27 ++
 rtl/fifo_uart_drain_if.sv | 20 ++
 rtl/fifo_uart_drain_bit_timer.sv | 35 +++
 rtl/fifo_uart_drain.sv | 116 +++++++++++
 tb/tb_fifo_uart_drain.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_drain_pkg.sv
// rtl/fifo_uart_drain_pkg.sv - shared state type and sizing helpers for the FIFO UART drain
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    HIGH,
    START,
    DATA,
    STOP
  } drain_state_t;

  localparam int DEFAULT_DATA_WIDTH     = 4;
  localparam int DEFAULT_CLOCKS_PER_BIT = 16;
  localparam int FRAME_BITS             = 2 * DEFAULT_DATA_WIDTH;
  localparam int BIT_COUNTER_WIDTH      = $clog2(DEFAULT_CLOCKS_PER_BIT);

  function automatic int frame_bits(input int data_width);
    return 2 * data_width;
  endfunction

  // Never let a counter collapse to zero width for the smallest legal divisors.
  function automatic int counter_width(input int terminal_count);
    return (terminal_count > 2) ? $clog2(terminal_count) : 1;
  endfunction

endpackage

// File: rtl/fifo_uart_drain_if.sv
// rtl/fifo_uart_drain_if.sv - FIFO read-port bundle between the FIFO and its UART drain
interface fifo_uart_drain_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  empty;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_increment;

  modport master (
    output empty,
    output read_data,
    input  read_increment
  );

  modport slave (
    input  empty,
    input  read_data,
    output read_increment
  );
endinterface

// File: rtl/fifo_uart_drain_bit_timer.sv
// rtl/fifo_uart_drain_bit_timer.sv - UART bit-period counter, restarted on every FSM state entry
module bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic read_clock,
  input  logic read_reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = counter_width(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign bit_done = (count_q == LAST);

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || bit_done) begin
      count_d = '0;
    end
  end

  always_ff @(posedge read_clock or posedge read_reset) begin
    if (read_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_uart_drain.sv
// rtl/fifo_uart_drain.sv - pops two FIFO words per byte and sends it as an 8N1 frame, LSB first
module fifo_uart_drain
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic                    read_clock,
  input  logic                    read_reset,
  input  logic                    enable,
  fifo_uart_drain_if.slave        fifo,
  output logic                    tx,
  output logic                    busy,
  output logic [7:0]              frame_count
);

  localparam int FRAME_W = frame_bits(DATA_WIDTH);
  localparam int IDX_W   = counter_width(FRAME_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

  drain_state_t       state_q, state_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               tx_q, tx_d;
  logic [7:0]         count_q, count_d;
  logic               bit_done;
  logic               pop;
  logic               timer_clear;

  assign pop = !read_reset && !fifo.empty && ((state_q == IDLE && enable) || state_q == HIGH);

  assign fifo.read_increment = pop;
  assign tx                  = tx_q;
  assign busy                = (state_q != IDLE);
  assign frame_count         = count_q;
  assign timer_clear         = (state_d != state_q);

  bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .read_clock(read_clock),
    .read_reset(read_reset),
    .clear     (timer_clear),
    .bit_done  (bit_done)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          data_d[DATA_WIDTH-1:0] = fifo.read_data;
          state_d                = SETTLE;
        end
      end
      // One dead cycle so the FIFO can refresh empty after the low-word pop.
      SETTLE: state_d = HIGH;
      HIGH: begin
        if (pop) begin
          data_d[FRAME_W-1:DATA_WIDTH] = fifo.read_data;
          state_d                      = START;
          tx_d                         = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = data_q[idx_q + 1'b1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          count_d = count_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge read_clock or posedge read_reset) begin
    if (read_reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb/tb_fifo_uart_drain.sv - directed self-checking bench for fifo_uart_drain
module tb_fifo_uart_drain;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       tx;
  logic       busy;
  logic [7:0] frame_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_uart_drain_if #(.DATA_WIDTH(4)) bus ();

  fifo_uart_drain #(
    .DATA_WIDTH    (4),
    .CLOCKS_PER_BIT(16)
  ) dut (
    .read_clock (clk),
    .read_reset (rst),
    .enable     (enable),
    .fifo       (bus),
    .tx         (tx),
    .busy       (busy),
    .frame_count(frame_count)
  );

  // FIFO model: words appear as soon as pushed, a pop takes effect at the rising edge.
  logic [3:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cycle = 0;
  int pops = 0;
  int pop_cyc_last = -1;
  int pop_cyc_prev = -1;
  int mon_bad = 0;
  logic ri_prev = 1'b0;

  assign bus.empty     = (wr_ptr == rd_ptr);
  assign bus.read_data = mem[rd_ptr % 1024];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (bus.read_increment) begin
      rd_ptr       <= rd_ptr + 1;
      pops         <= pops + 1;
      pop_cyc_prev <= pop_cyc_last;
      pop_cyc_last <= cycle;
    end
  end

  always @(negedge clk) begin
    if (bus.read_increment && bus.empty) mon_bad <= mon_bad + 1;
    if (bus.read_increment && ri_prev) mon_bad <= mon_bad + 1;
    ri_prev <= bus.read_increment;
  end

  task automatic push(input logic [3:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_fall(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < budget);
  endtask

  // Called on the first negedge of a start bit; ends on the last negedge of the stop bit.
  task automatic rx_frame(output logic [7:0] b, output bit ok);
    logic lvl;
    logic s;
    ok  = 1'b1;
    b   = '0;
    lvl = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 16; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        s = tx;
        if (j == 0) lvl = s;
        else if (s !== lvl) ok = 1'b0;
      end
      if (k == 0 && lvl !== 1'b0) ok = 1'b0;
      if (k == 9 && lvl !== 1'b1) ok = 1'b0;
      if (k >= 1 && k <= 8) b[k-1] = lvl;
    end
  endtask

  task automatic test_reset();
    bit bad;
    bad = 1'b0;
    enable = 1'b1;
    push(4'h5);
    push(4'hA);
    repeat (8) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || bus.read_increment !== 1'b0 || frame_count !== 8'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_hold: tx=%b busy=%b read_increment=%b frame_count=%0d, required 1 0 0 0",
               tx, busy, bus.read_increment, frame_count);
    end
    checks++;
    if (pops !== 0) begin
      errors++;
      $display("FAIL reset_no_pop: pops=%0d, required 0", pops);
    end
  endtask

  task automatic test_basic_frame();
    int n;
    int fall_cyc;
    logic [7:0] b;
    bit ok;
    rst = 1'b0;
    wait_fall(20, n);
    fall_cyc = cycle;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL basic_latency: edges=%0d, required 3", n);
    end
    checks++;
    if (pops !== 2 || pop_cyc_last - pop_cyc_prev !== 2) begin
      errors++;
      $display("FAIL basic_pop_spacing: pops=%0d spacing=%0d, required 2 2", pops, pop_cyc_last - pop_cyc_prev);
    end
    checks++;
    if (fall_cyc !== pop_cyc_last + 1) begin
      errors++;
      $display("FAIL basic_start_edge: fall cycle=%0d, required %0d", fall_cyc, pop_cyc_last + 1);
    end
    rx_frame(b, ok);
    checks++;
    if (!ok || b !== 8'hA5) begin
      errors++;
      $display("FAIL basic_frame: byte=%h shape_ok=%0d, required a5 1", b, ok);
    end
    @(negedge clk);
    checks++;
    if (frame_count !== 8'd1) begin
      errors++;
      $display("FAIL basic_count: frame_count=%0d, required 1", frame_count);
    end
  endtask

  task automatic test_starved_high();
    int n;
    bit bad;
    logic [7:0] b;
    bit ok;
    bad = 1'b0;
    push(4'h3);
    @(negedge clk);
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b1 || tx !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || pops !== 3) begin
      errors++;
      $display("FAIL starved_wait: busy=%b tx=%b pops=%0d, required 1 1 3", busy, tx, pops);
    end
    push(4'hC);
    wait_fall(10, n);
    checks++;
    if (n !== 1 || pops !== 4) begin
      errors++;
      $display("FAIL starved_resume: edges=%0d pops=%0d, required 1 4", n, pops);
    end
    rx_frame(b, ok);
    checks++;
    if (!ok || b !== 8'hC3) begin
      errors++;
      $display("FAIL starved_frame: byte=%h shape_ok=%0d, required c3 1", b, ok);
    end
    @(negedge clk);
    checks++;
    if (frame_count !== 8'd2) begin
      errors++;
      $display("FAIL starved_count: frame_count=%0d, required 2", frame_count);
    end
  endtask

  task automatic test_enable_gating();
    int n;
    int pops0;
    bit bad;
    logic [7:0] b;
    bit ok;
    bad = 1'b0;
    enable = 1'b0;
    pops0 = pops;
    push(4'h7);
    push(4'h2);
    push(4'h9);
    push(4'h6);
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || pops !== pops0) begin
      errors++;
      $display("FAIL gate_hold: tx=%b busy=%b pops=%0d, required 1 0 %0d", tx, busy, pops, pops0);
    end
    enable = 1'b1;
    wait_fall(10, n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL gate_start: edges=%0d, required 3", n);
    end
    fork
      begin
        repeat (16 + 48 + 8) @(negedge clk);
        enable = 1'b0;
      end
    join_none
    rx_frame(b, ok);
    checks++;
    if (!ok || b !== 8'h27) begin
      errors++;
      $display("FAIL gate_frame: byte=%h shape_ok=%0d, required 27 1", b, ok);
    end
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || pops !== pops0 + 2 || frame_count !== 8'd3) begin
      errors++;
      $display("FAIL gate_after_drop: tx=%b busy=%b pops=%0d frame_count=%0d, required 1 0 %0d 3",
               tx, busy, pops, frame_count, pops0 + 2);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int pops0;
    logic [7:0] b;
    bit ok;
    enable = 1'b1;
    wait_fall(10, n);
    repeat (88) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL midreset_bit4: tx=%b, required 0", tx);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_count !== 8'd0 || bus.read_increment !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: tx=%b busy=%b frame_count=%0d read_increment=%b, required 1 0 0 0",
               tx, busy, frame_count, bus.read_increment);
    end
    pops0 = pops;
    push(4'hE);
    push(4'h1);
    repeat (3) @(negedge clk);
    checks++;
    if (pops !== pops0) begin
      errors++;
      $display("FAIL midreset_no_pop: pops=%0d, required %0d", pops, pops0);
    end
    rst = 1'b0;
    wait_fall(10, n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL midreset_restart: edges=%0d, required 3", n);
    end
    rx_frame(b, ok);
    checks++;
    if (!ok || b !== 8'h1E) begin
      errors++;
      $display("FAIL midreset_frame: byte=%h shape_ok=%0d, required 1e 1", b, ok);
    end
    @(negedge clk);
    checks++;
    if (frame_count !== 8'd1) begin
      errors++;
      $display("FAIL midreset_count: frame_count=%0d, required 1", frame_count);
    end
  endtask

  task automatic test_streaming();
    int n;
    int pops0;
    logic [7:0] b;
    logic [7:0] expb;
    bit ok;
    bit bad;
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 512; i++) push(4'((i * 7) + 3));
    @(negedge clk);
    rst = 1'b0;
    pops0 = pops;
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 256; k++) begin
      wait_fall((k == 0) ? 10 : 40, n);
      if (k > 0) begin
        checks++;
        if (n - 1 !== 3) begin
          errors++;
          $display("FAIL stream_gap[%0d]: extra high cycles=%0d, required 3", k, n - 1);
        end
      end
      checks++;
      if (frame_count !== 8'(k)) begin
        errors++;
        $display("FAIL stream_count[%0d]: frame_count=%0d, required %0d", k, frame_count, k);
      end
      expb = {4'(((2 * k + 1) * 7) + 3), 4'(((2 * k) * 7) + 3)};
      rx_frame(b, ok);
      checks++;
      if (!ok || b !== expb) begin
        errors++;
        $display("FAIL stream_frame[%0d]: byte=%h shape_ok=%0d, required %h 1", k, b, ok, expb);
      end
    end
    @(negedge clk);
    checks++;
    if (frame_count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_wrap: frame_count=%0d busy=%b, required 0 0", frame_count, busy);
    end
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || pops !== pops0 + 512) begin
      errors++;
      $display("FAIL stream_drained: tx=%b pops=%0d, required 1 %0d", tx, pops, pops0 + 512);
    end
  endtask

  task automatic test_pop_rules();
    checks++;
    if (mon_bad !== 0) begin
      errors++;
      $display("FAIL pop_rules: violations=%0d, required 0", mon_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_starved_high();
    test_enable_gating();
    test_reset_mid_frame();
    test_streaming();
    test_pop_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
